mask_pixel_streamer: RTL and testbench

Frame-scan source that feeds the centroid stage. On a start pulse it reads a 1-bit detection mask (WIDTH×HEIGHT, row-major) from a frame-buffer BRAM and emits one coordinate per mask pixel with `valid_out` set where the mask bit is 1. After the last pixel it emits the end-of-frame sentinel coordinate (x=WIDTH, y=HEIGHT). After a settle delay it pulses `tabulate_out` so the downstream centre-of-mass block latches its result.

---
 rtl/mask_pixel_streamer_if.sv | 34 +++
 rtl/mask_pixel_streamer.sv | 144 ++++++++++++++
 tb/tb_mask_pixel_streamer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mask_pixel_streamer_if.sv
// Scan-source bus: start request, BRAM read port and the
// coordinate stream handed to the centroid stage.
interface mask_pixel_streamer_if;
    logic        start_in;
    logic        mem_data_in;
    logic [16:0] addr_out;
    logic [7:0]  x_out;
    logic [8:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;
    logic        busy_out;

    modport master (
        input  start_in,
        input  mem_data_in,
        output addr_out,
        output x_out,
        output y_out,
        output valid_out,
        output tabulate_out,
        output busy_out
    );

    modport slave (
        output start_in,
        output mem_data_in,
        input  addr_out,
        input  x_out,
        input  y_out,
        input  valid_out,
        input  tabulate_out,
        input  busy_out
    );
endinterface

// File: rtl/mask_pixel_streamer.sv
// Mask frame scanner feeding the centroid stage with coordinates + sentinel.
// Define MASK_STREAMER_SUBSAMPLE_EN to visit only even x / even y.
module mask_pixel_streamer #(
    parameter int WIDTH        = 240,
    parameter int HEIGHT       = 320,
    parameter int READ_LATENCY = 2,
    parameter int TAB_DELAY    = 64
) (
    input  logic clk_in,
    input  logic rst_in,
    mask_pixel_streamer_if.master bus
);

`ifdef MASK_STREAMER_SUBSAMPLE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam logic [7:0]  X_LAST    = 8'(WIDTH - STEP);
    localparam logic [8:0]  Y_LAST    = 9'(HEIGHT - STEP);
    localparam logic [7:0]  X_STEP    = 8'(STEP);
    localparam logic [8:0]  Y_STEP    = 9'(STEP);
    localparam logic [16:0] A_STEP    = 17'(STEP);
    localparam logic [16:0] A_ROW     = 17'(STEP * WIDTH);
    localparam logic [15:0] DRAIN_END = 16'(READ_LATENCY);
    localparam logic [15:0] WAIT_END  = 16'(TAB_DELAY - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_MARK, S_WAIT, S_TAB
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [7:0]  r_x;
    logic [8:0]  r_y;
    logic [16:0] r_addr;
    logic        w_row_end;
    logic        w_last;

    logic [7:0]  r_dx [READ_LATENCY];
    logic [8:0]  r_dy [READ_LATENCY];
    logic        r_dt [READ_LATENCY];
    logic [7:0]  r_xo;
    logic [8:0]  r_yo;
    logic        r_vo;

    assign w_row_end = (r_x >= X_LAST);
    assign w_last    = w_row_end && (r_y >= Y_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start_in) w_next = S_SCAN;
            S_SCAN:  if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_cnt == DRAIN_END) w_next = S_MARK;
            S_MARK:  w_next = (TAB_DELAY > 1) ? S_WAIT : S_TAB;
            S_WAIT:  if (r_cnt == WAIT_END) w_next = S_TAB;
            S_TAB:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Row wrap rewinds by x and jumps STEP rows, so no multiplier is needed.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (r_state == S_IDLE && bus.start_in) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (r_state == S_SCAN && !w_last) begin
            if (w_row_end) begin
                r_x    <= '0;
                r_y    <= r_y + Y_STEP;
                r_addr <= r_addr + A_ROW - 17'(r_x);
            end else begin
                r_x    <= r_x + X_STEP;
                r_addr <= r_addr + A_STEP;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_dx[i] <= '0;
                r_dy[i] <= '0;
                r_dt[i] <= 1'b0;
            end
            r_xo <= '0;
            r_yo <= '0;
            r_vo <= 1'b0;
        end else begin
            r_dx[0] <= r_x;
            r_dy[0] <= r_y;
            r_dt[0] <= (r_state == S_SCAN);
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_dx[i] <= r_dx[i-1];
                r_dy[i] <= r_dy[i-1];
                r_dt[i] <= r_dt[i-1];
            end
            r_xo <= r_dt[READ_LATENCY-1] ? r_dx[READ_LATENCY-1] : 8'd0;
            r_yo <= r_dt[READ_LATENCY-1] ? r_dy[READ_LATENCY-1] : 9'd0;
            r_vo <= r_dt[READ_LATENCY-1] & bus.mem_data_in;
        end
    end

    always_comb begin
        bus.addr_out     = r_addr;
        bus.x_out        = '0;
        bus.y_out        = '0;
        bus.valid_out    = 1'b0;
        bus.tabulate_out = 1'b0;
        bus.busy_out     = (r_state != S_IDLE);
        unique case (r_state)
            S_SCAN, S_DRAIN: begin
                bus.x_out     = r_xo;
                bus.y_out     = r_yo;
                bus.valid_out = r_vo;
            end
            S_MARK: begin
                bus.x_out = 8'(WIDTH);
                bus.y_out = 9'(HEIGHT);
            end
            S_TAB:   bus.tabulate_out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mask_pixel_streamer.sv
// Directed + random frame scans of mask_pixel_streamer on a small
// frame, checked cycle by cycle against an arithmetic timing model.
module tb_mask_pixel_streamer;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int L  = 2;
    localparam int TD = 8;
`ifdef MASK_STREAMER_SUBSAMPLE_EN
    localparam int SS = 2;
`else
    localparam int SS = 1;
`endif
    localparam int VW = W / SS;
    localparam int N  = VW * (H / SS);
    localparam int S  = N + L + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mask_pixel_streamer_if bus ();

    mask_pixel_streamer #(
        .WIDTH(W),
        .HEIGHT(H),
        .READ_LATENCY(L),
        .TAB_DELAY(TD)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    logic mask [W*H];
    logic q [L];

    always @(posedge clk) begin
        q[0] <= mask[bus.addr_out];
        for (int i = 1; i < L; i++) q[i] <= q[i-1];
    end
    assign bus.mem_data_in = q[L-1];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s cycle %0d: got %0d expected %0d",
                   tag, c, obs, exp);
        end
    endtask

    function automatic int vx(input int k);
        return (k % VW) * SS;
    endfunction

    function automatic int vy(input int k);
        return (k / VW) * SS;
    endfunction

    function automatic int va(input int k);
        return vy(k) * W + vx(k);
    endfunction

    function automatic int mask_count();
        int n = 0;
        for (int k = 0; k < N; k++) if (mask[va(k)] === 1'b1) n++;
        return n;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < W*H; i++)
            mask[i] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of
    // cycle S+TD+1 (idle again) with start_in left at 'hold'.
    task automatic run_frame(input bit hold, output int nv, output int lastv);
        int k;
        nv = 0;
        lastv = -1;
        bus.start_in = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= S + TD + 1; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_in = hold;
            chk("busy", c, 32'(bus.busy_out), (c <= S + TD) ? 1 : 0);
            chk("tab", c, 32'(bus.tabulate_out), (c == S + TD) ? 1 : 0);
            if (c <= N)
                chk("addr", c, 32'(bus.addr_out), va(c - 1));
            else if (c <= N + L + 1)
                chk("addr_hold", c, 32'(bus.addr_out), va(N - 1));
            if (bus.valid_out === 1'b1) begin
                nv++;
                lastv = c;
            end
            if (c >= L + 2 && c <= N + L + 1) begin
                k = c - L - 2;
                chk("x", c, 32'(bus.x_out), vx(k));
                chk("y", c, 32'(bus.y_out), vy(k));
                chk("valid", c, 32'(bus.valid_out), 32'(mask[va(k)]));
            end else if (c == S) begin
                chk("sent_x", c, 32'(bus.x_out), W);
                chk("sent_y", c, 32'(bus.y_out), H);
                chk("sent_v", c, 32'(bus.valid_out), 0);
            end else if (c > S && c <= S + TD) begin
                chk("wait_x", c, 32'(bus.x_out), 0);
                chk("wait_y", c, 32'(bus.y_out), 0);
                chk("wait_v", c, 32'(bus.valid_out), 0);
            end else begin
                chk("quiet_v", c, 32'(bus.valid_out), 0);
            end
        end
    endtask

    initial begin
        int nv;
        int lv;
        int bx;
        int by;
        int bad;

        bus.start_in = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        chk("rst_addr", 0, 32'(bus.addr_out), 0);
        chk("rst_x", 0, 32'(bus.x_out), 0);
        chk("rst_y", 0, 32'(bus.y_out), 0);
        chk("rst_v", 0, 32'(bus.valid_out), 0);
        chk("rst_tab", 0, 32'(bus.tabulate_out), 0);
        chk("rst_busy", 0, 32'(bus.busy_out), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b0, nv, lv);
        chk("zero_count", 0, nv, 0);

        bx = 10;
        by = (SS == 2) ? 6 : 5;
        mask[by * W + bx] = 1'b1;
        run_frame(1'b0, nv, lv);
        chk("single_count", 0, nv, 1);
        chk("single_cycle", 0, lv, (by / SS) * VW + bx / SS + L + 2);

        fill(1);
        run_frame(1'b0, nv, lv);
        chk("ones_count", 0, nv, N);
        chk("ones_last", 0, lv, N + L + 1);

        fill(2);
        run_frame(1'b1, nv, lv);
        chk("hold_count", 0, nv, mask_count());
        fill(2);
        run_frame(1'b0, nv, lv);
        chk("rand_count", 0, nv, mask_count());

        bus.start_in = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_in = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_addr", 51, 32'(bus.addr_out), 0);
        chk("abort_x", 51, 32'(bus.x_out), 0);
        chk("abort_y", 51, 32'(bus.y_out), 0);
        chk("abort_v", 51, 32'(bus.valid_out), 0);
        chk("abort_tab", 51, 32'(bus.tabulate_out), 0);
        chk("abort_busy", 51, 32'(bus.busy_out), 0);
        rst = 1'b0;
        bad = 0;
        repeat (S + TD + 5) begin
            @(negedge clk);
            if (bus.tabulate_out !== 1'b0 || bus.busy_out !== 1'b0 ||
                bus.valid_out !== 1'b0 || bus.x_out == 8'(W))
                bad++;
        end
        chk("abort_quiet", 0, bad, 0);

        fill(2);
        run_frame(1'b0, nv, lv);
        chk("post_abort_count", 0, nv, mask_count());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
